// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, the
// unsigned-extension bit position and the responder FSM states.
package dmem_responder_pkg;

  localparam logic [1:0] BHW_B = 2'b00;
  localparam logic [1:0] BHW_H = 2'b01;
  localparam logic [1:0] BHW_W = 2'b10;

  localparam int BHW_UNS_BIT = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store lane enables and data placement,
// load extraction with sign/zero extension, and illegal-access detection.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  bhw,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  lane_en,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);

  function automatic logic [31:0] extend(input logic [15:0] v, input logic half,
                                         input logic uns);
    logic signed [31:0] sx;
    if (half) begin
      if (uns) return {16'h0000, v};
      sx = 32'($signed(v));
      return sx;
    end
    if (uns) return {24'h000000, v[7:0]};
    sx = 32'($signed(v[7:0]));
    return sx;
  endfunction

  logic        uns;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign uns = bhw[BHW_UNS_BIT];

  // misalign also covers the reserved size so the caller sees one error flag
  always_comb begin
    lane_en  = '0;
    wword    = wdata;
    rdata    = '0;
    misalign = 1'b0;
    sel_byte = rword[{addr_lo, 3'b000} +: 8];
    sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (bhw[1:0])
      BHW_B: begin
        lane_en = 4'b0001 << addr_lo;
        wword   = {4{wdata[7:0]}};
        rdata   = extend({8'h00, sel_byte}, 1'b0, uns);
      end
      BHW_H: begin
        misalign = addr_lo[0];
        lane_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        rdata    = extend(sel_half, 1'b1, uns);
      end
      BHW_W: begin
        misalign = |addr_lo;
        lane_en  = 4'b1111;
        rdata    = rword;
      end
      default: misalign = 1'b1;
    endcase
    if (misalign) begin
      lane_en = '0;
      rdata   = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Request/response data-memory responder: latches one load/store, waits a
// fixed latency, executes against four byte-wide RAM lanes and pulses a response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_bhw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam bit         DIRECT   = (LATENCY == 1);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t state, state_nxt;
  logic [3:0]    cnt;
  logic          accept, exec;

  logic          we_p0;
  logic [2:0]    bhw_p0;
  logic [AW+1:0] addr_p0;
  logic [31:0]   wdata_p0;

  logic          op_we;
  logic [2:0]    op_bhw;
  logic [AW+1:0] op_addr;
  logic [31:0]   op_wdata;
  logic [AW-1:0] idx;

  logic [3:0]    lane_en;
  logic [31:0]   wword, rword, rdata;
  logic          misalign;
  logic          addr_unused;

  assign addr_unused = ^req_addr[31:AW+2];

  assign req_ready  = (state != WAIT);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid & req_ready;

  // With single-cycle latency the access executes on the accepting edge itself
  assign op_we    = DIRECT ? req_we             : we_p0;
  assign op_bhw   = DIRECT ? req_bhw            : bhw_p0;
  assign op_addr  = DIRECT ? req_addr[AW+1:0]   : addr_p0;
  assign op_wdata = DIRECT ? req_wdata          : wdata_p0;
  assign idx      = op_addr[AW+1:2];

  always_comb begin
    state_nxt = state;
    exec      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = DIRECT ? RESP : WAIT;
          exec      = DIRECT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          exec      = 1'b1;
        end
      end
      RESP: begin
        if (accept) begin
          state_nxt = DIRECT ? RESP : WAIT;
          exec      = DIRECT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CNT_LOAD;
      else if (state == WAIT)
        cnt <= cnt - 4'd1;
    end
  end

  // Request capture stage
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      bhw_p0   <= req_bhw;
      addr_p0  <= req_addr[AW+1:0];
      wdata_p0 <= req_wdata;
    end
  end

  dmem_lane_align u_align (
    .bhw      (op_bhw),
    .addr_lo  (op_addr[1:0]),
    .wdata    (op_wdata),
    .rword    (rword),
    .lane_en  (lane_en),
    .wword    (wword),
    .rdata    (rdata),
    .misalign (misalign)
  );

  // Execute stage: RAM write and response capture share the edge entering RESP
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (exec && !rst && op_we && lane_en[l])
        mem[idx] <= wword[8*l +: 8];
    end
    assign rword[8*l +: 8] = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (exec) begin
      resp_err   <= misalign;
      resp_rdata <= op_we ? '0 : rdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random load/store traffic scored
// against a byte-addressed memory model with per-request latency tracking.
module tb_dmem_responder;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_bhw;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  dmem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_bhw(req_bhw), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  bhw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc;
    bit          has_fix;
    logic [31:0] fix_rd;
    logic        fix_err;
  } req_t;

  req_t        q[$];
  logic [7:0]  mm [4096];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  bit          cur_has_fix = 0;
  logic [31:0] cur_fix_rd = '0;
  logic        cur_fix_err = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: memory as a flat byte array, access = nbytes little-endian bytes
  function automatic void model_exec(input req_t t, output logic [31:0] rd, output logic er);
    int nb;
    int a;
    logic [31:0] v;
    a = int'(t.addr[11:0]);
    case (t.bhw[1:0])
      2'd0: nb = 1;
      2'd1: nb = 2;
      2'd2: nb = 4;
      default: nb = 0;
    endcase
    er = (nb == 0) || (a % nb != 0);
    rd = '0;
    if (!er) begin
      if (t.we) begin
        for (int i = 0; i < nb; i++) mm[a + i] = t.wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(mm[a + i]) << (8 * i));
        if (nb == 4 || t.bhw[2]) rd = v;
        else if (nb == 1) rd = {{24{v[7]}}, v[7:0]};
        else rd = {{16{v[15]}}, v[15:0]};
      end
    end
  endfunction

  always @(posedge clk) begin
    req_t e;
    if (rst) begin
      q.delete();
    end else if (req_valid && req_ready) begin
      e.we = req_we; e.bhw = req_bhw; e.addr = req_addr; e.wdata = req_wdata;
      e.acc = cyc; e.has_fix = cur_has_fix; e.fix_rd = cur_fix_rd; e.fix_err = cur_fix_err;
      q.push_back(e);
    end
    cyc++;
  end

  always @(posedge clk) begin
    req_t t;
    bit due, exp_ready;
    logic [31:0] erd;
    logic eer;
    #1;
    due       = (q.size() > 0) && (q[0].acc + LAT == cyc);
    exp_ready = (q.size() == 0) || (q[0].acc + LAT <= cyc);
    check_val("req_ready", 32'(req_ready), 32'(exp_ready));
    check_val("resp_valid", 32'(resp_valid), 32'(due));
    if (due) begin
      t = q.pop_front();
      model_exec(t, erd, eer);
      check_val("resp_rdata", resp_rdata, erd);
      check_val("resp_err", 32'(resp_err), 32'(eer));
      if (t.has_fix) begin
        check_val("plan_rdata", resp_rdata, t.fix_rd);
        check_val("plan_err", 32'(resp_err), 32'(t.fix_err));
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] bhw, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit has_fix, input logic [31:0] fix_rd,
                      input logic fix_err, input bit keep, input int hold);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_bhw = bhw; req_addr = addr; req_wdata = wdata;
    cur_has_fix = has_fix; cur_fix_rd = fix_rd; cur_fix_err = fix_err;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_val("ready_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    req_valid = keep;
    req_we = 1'($urandom); req_bhw = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    cur_has_fix = 0;
    repeat (hold) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check_val("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    bit k;
    for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_bhw = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", 32'(req_ready), 32'd1);
    check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst_rdata", resp_rdata, 32'd0);
    check_val("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;

    // zero the exercised region, with random upper bits to hit address wrap
    for (int a = 0; a < 256; a += 4)
      send(1'b1, 3'b010, ($urandom & 32'hFFFFF000) | a, 32'h0, 1, 32'h0, 1'b0, 0, 0);
    drain();

    send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0, 0, 0);
    send(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0, 0, 0);
    send(1'b0, 3'b000, 32'h11, 32'h0, 1, 32'hFFFFFFBE, 1'b0, 0, 0);
    send(1'b0, 3'b100, 32'h11, 32'h0, 1, 32'h000000BE, 1'b0, 0, 0);
    send(1'b0, 3'b001, 32'h12, 32'h0, 1, 32'hFFFFDEAD, 1'b0, 0, 0);
    send(1'b0, 3'b101, 32'h12, 32'h0, 1, 32'h0000DEAD, 1'b0, 0, 0);
    send(1'b1, 3'b000, 32'h13, 32'hAAAAAA55, 1, 32'h0, 1'b0, 0, 0);
    send(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h55ADBEEF, 1'b0, 0, 0);
    send(1'b1, 3'b001, 32'h21, 32'h0000CAFE, 1, 32'h0, 1'b1, 0, 0);
    send(1'b0, 3'b010, 32'h20, 32'h0, 1, 32'h0, 1'b0, 0, 0);
    send(1'b0, 3'b010, 32'h22, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    send(1'b0, 3'b011, 32'h30, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    drain();

    // back-to-back with valid held high and junk fields during WAIT
    send(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h55ADBEEF, 1'b0, 1, 1);
    send(1'b0, 3'b000, 32'h13, 32'h0, 1, 32'h00000055, 1'b0, 1, 1);
    send(1'b1, 3'b010, 32'h14, 32'hA1B2C3D4, 1, 32'h0, 1'b0, 1, 1);
    send(1'b0, 3'b001, 32'h16, 32'h0, 1, 32'hFFFFA1B2, 1'b0, 0, 0);
    drain();

    // reset sampled mid-WAIT, then reset landing on the execute edge
    send(1'b1, 3'b010, 32'h40, 32'h12345678, 0, 32'h0, 1'b0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_ready", 32'(req_ready), 32'd1);
    check_val("abort_resp_valid", 32'(resp_valid), 32'd0);
    send(1'b0, 3'b010, 32'h40, 32'h0, 1, 32'h0, 1'b0, 0, 0);
    drain();
    send(1'b1, 3'b010, 32'h40, 32'h87654321, 0, 32'h0, 1'b0, 0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort2_resp_valid", 32'(resp_valid), 32'd0);
    send(1'b0, 3'b010, 32'h40, 32'h0, 1, 32'h0, 1'b0, 0, 0);
    drain();

    for (int i = 0; i < 300; i++) begin
      k = ($urandom_range(0, 3) == 0) && (i != 299);
      send(1'($urandom), 3'($urandom), ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255)),
           $urandom, 0, 32'h0, 1'b0, k, k ? 1 : $urandom_range(0, 2));
    end
    req_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
